// File: rtl/led_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_arbiter_pkg : shared state encoding and constants for led_arbiter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package led_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int RGB_W        = 3;
  localparam int DEF_TICK_TAP = 3;

endpackage
`default_nettype wire

// File: rtl/led_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : one-hot round-robin pick, search starts at ptr           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_arbiter : round-robin LED ownership with tick-timed holds         |
// | Optional: LED_ARBITER_PREEMPT_EN lets requester 0 cut a grant short.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DUR_W    = 8,
  parameter int NTAPS    = 6,
  parameter int TICK_TAP = DEF_TICK_TAP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NTAPS-1:0]          taps,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [RGB_W*NREQ-1:0]     req_rgb,
  input  logic [DUR_W*NREQ-1:0]     req_dur,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           done,
  output logic                      r,
  output logic                      g,
  output logic                      b,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OWN_W = $clog2(NREQ);

  state_t             r_state;
  logic [OWN_W-1:0]   r_rr_ptr;
  logic [OWN_W-1:0]   r_owner;
  logic [DUR_W-1:0]   r_count;
  logic [RGB_W-1:0]   r_rgb;
  logic [NREQ-1:0]    r_done;

  logic [NREQ-1:0]    w_grant;
  logic [OWN_W-1:0]   w_ptr;
  logic [OWN_W-1:0]   w_sel_idx;
  logic [RGB_W-1:0]   w_sel_rgb;
  logic [DUR_W-1:0]   w_sel_dur;
  logic [OWN_W-1:0]   w_next_ptr;
  logic [NREQ-1:0]    w_owner_oh;
  logic               w_tick;
  logic               w_accept;
  logic               w_preempt_hit;
  logic               w_taps_unused;

  assign w_tick        = taps[TICK_TAP];
  assign w_taps_unused = ^taps;
  assign w_accept      = (r_state == IDLE) && (|req_valid);
  assign w_owner_oh    = NREQ'(1) << r_owner;

`ifdef LED_ARBITER_PREEMPT_EN
  logic r_preempt;

  // After a preemption the next IDLE search starts at requester 0.
  assign w_ptr         = r_preempt ? '0 : r_rr_ptr;
  assign w_preempt_hit = (r_state == ACTIVE) && req_valid[0] && (r_owner != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preempt <= 1'b0;
    end else if (w_preempt_hit) begin
      r_preempt <= 1'b1;
    end else if (w_accept) begin
      r_preempt <= 1'b0;
    end
  end
`else
  assign w_ptr         = r_rr_ptr;
  assign w_preempt_hit = 1'b0;
`endif

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (OWN_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (w_ptr),
    .grant (w_grant)
  );

  always_comb begin
    w_sel_idx = '0;
    w_sel_rgb = '0;
    w_sel_dur = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = OWN_W'(i);
        w_sel_rgb = req_rgb[RGB_W*i +: RGB_W];
        w_sel_dur = req_dur[DUR_W*i +: DUR_W];
      end
    end
  end

  assign w_next_ptr = (w_sel_idx == OWN_W'(NREQ - 1)) ? '0 : w_sel_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_count  <= '0;
      r_rgb    <= '0;
      r_done   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner  <= w_sel_idx;
            r_rr_ptr <= w_next_ptr;
            r_count  <= (w_sel_dur == '0) ? DUR_W'(1) : w_sel_dur;
            r_rgb    <= w_sel_rgb;
            r_state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_preempt_hit) begin
            r_done  <= w_owner_oh;
            r_rgb   <= '0;
            r_count <= '0;
            r_state <= IDLE;
          end else if (w_tick) begin
            if (r_count == DUR_W'(1)) begin
              r_done  <= w_owner_oh;
              r_rgb   <= '0;
              r_count <= '0;
              r_state <= GAP;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated with rst_n so nothing is accepted while reset is held.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_grant : '0;
  assign done      = r_done;
  assign r         = r_rgb[2];
  assign g         = r_rgb[1];
  assign b         = r_rgb[0];
  assign busy      = (r_state != IDLE);
  assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_arbiter : directed vector table plus corner-case sequences     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_led_arbiter;

  localparam int NREQ     = 4;
  localparam int DUR_W    = 8;
  localparam int NTAPS    = 6;
  localparam int TICK_TAP = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NTAPS-1:0]      taps = '0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [3*NREQ-1:0]     req_rgb = '0;
  logic [DUR_W*NREQ-1:0] req_dur = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       done;
  logic                  r, g, b, busy;
  logic [1:0]            owner;

  int checks = 0;
  int errors = 0;

  led_arbiter #(
    .NREQ(NREQ), .DUR_W(DUR_W), .NTAPS(NTAPS), .TICK_TAP(TICK_TAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .taps(taps), .req_valid(req_valid),
    .req_rgb(req_rgb), .req_dur(req_dur), .req_ready(req_ready),
    .done(done), .r(r), .g(g), .b(b), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [11:0] rgb;
    logic [31:0] dur;
    logic        tick;
    logic [3:0]  ready;
    logic [2:0]  led;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic [3:0] v, input logic [11:0] rgb, input logic [31:0] dur,
                       input logic tick);
    @(posedge clk);
    #1;
    req_valid      = v;
    req_rgb        = rgb;
    req_dur        = dur;
    taps           = NTAPS'($urandom);
    taps[TICK_TAP] = tick;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    taps      = '0;
    #2;
    rst_n     = 1'b1;
  endtask

  initial begin
    int n;
    int lit;
    int dones;
    int seen_r1;
    int seen_d1;
    int d0;
    int ord[5];
    logic [3:0] fair_mask;

    // Single grant dur=3 with a tick in the acceptance cycle, then dur=0 on requester 2.
    tbl[0]  = '{4'b0001, 12'h004, 32'h0000_0003, 1'b1, 4'b0001, 3'b000, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b100, 4'b0000, 1'b1, 2'd0};
    tbl[2]  = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b100, 4'b0000, 1'b1, 2'd0};
    tbl[3]  = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b100, 4'b0000, 1'b1, 2'd0};
    tbl[4]  = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b100, 4'b0000, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b100, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b000, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b000, 4'b0000, 1'b1, 2'd0};
    tbl[8]  = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b000, 4'b0000, 1'b1, 2'd0};
    tbl[9]  = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0, 2'd0};
    tbl[10] = '{4'b0100, 12'h0C0, 32'h0,          1'b0, 4'b0100, 3'b000, 4'b0000, 1'b0, 2'd0};
    tbl[11] = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b011, 4'b0000, 1'b1, 2'd2};
    tbl[12] = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b000, 4'b0100, 1'b1, 2'd2};
    tbl[13] = '{4'b0000, 12'h000, 32'h0,          1'b1, 4'b0000, 3'b000, 4'b0000, 1'b1, 2'd2};
    tbl[14] = '{4'b0000, 12'h000, 32'h0,          1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0, 2'd2};

    // Reset state, with every request raised to confirm nothing is accepted in reset.
    req_valid = 4'hF;
    #12;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_led",   {r, g, b}, 3'b000);
    check("rst_done",  done,      4'b0000);
    check("rst_busy",  busy,      1'b0);
    check("rst_owner", owner,     2'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].rgb, tbl[i].dur, tbl[i].tick);
      check($sformatf("vec%0d_ready", i), req_ready, tbl[i].ready);
      check($sformatf("vec%0d_led", i),   {r, g, b}, tbl[i].led);
      check($sformatf("vec%0d_done", i),  done,      tbl[i].done);
      check($sformatf("vec%0d_busy", i),  busy,      tbl[i].busy);
      check($sformatf("vec%0d_owner", i), owner,     tbl[i].owner);
    end

    // Fairness: everyone valid, dur=1, tick every cycle.
    do_reset();
`ifdef LED_ARBITER_PREEMPT_EN
    fair_mask = 4'hE;
    ord = '{1, 2, 3, 1, 2};
`else
    fair_mask = 4'hF;
    ord = '{0, 1, 2, 3, 0};
`endif
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      drive(fair_mask, 12'hFFF, 32'h0101_0101, 1'b1);
      if (req_ready != 4'b0000) begin
        check($sformatf("fair_grant%0d", n), req_ready, 32'd1 << ord[n]);
        n++;
      end
    end
    check("fair_grant_count", n, 5);

    // Longest hold: dur=255 on requester 3, tick every cycle.
    do_reset();
    drive(4'b1000, 12'hA00, 32'hFF00_0000, 1'b1);
    check("max_ready", req_ready, 4'b1000);
    lit = 0;
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      drive(4'b0000, 12'h000, 32'h0, 1'b1);
      if ({r, g, b} == 3'b101) lit++;
      if (done == 4'b1000) dones++;
    end
    check("max_lit_ticks", lit, 255);
    check("max_done_count", dones, 1);
    check("max_busy_after", busy, 1'b0);

    // Reset at tick 2 of a 5-tick grant held by requester 2.
    do_reset();
    drive(4'b0100, 12'h1C0, 32'h0005_0000, 1'b0);
    check("rmid_ready", req_ready, 4'b0100);
    drive(4'b0000, 12'h000, 32'h0, 1'b1);
    drive(4'b0000, 12'h000, 32'h0, 1'b0);
    drive(4'b0000, 12'h000, 32'h0, 1'b1);
    check("rmid_led_before", {r, g, b}, 3'b111);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    check("rmid_led",   {r, g, b}, 3'b000);
    check("rmid_busy",  busy,      1'b0);
    check("rmid_done",  done,      4'b0000);
    check("rmid_ready_in_reset", req_ready, 4'b0000);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmid_next_grant", req_ready, 4'b0001);
    check("rmid_no_done", done, 4'b0000);
    drive(4'b0000, 12'h000, 32'h0, 1'b0);
    check("rmid_no_done2", done, 4'b0000);

    // Withdrawal: requester 1 asks during requester 0's grant and gives up.
    do_reset();
    drive(4'b0001, 12'h007, 32'h0000_0002, 1'b0);
    check("wd_ready0", req_ready, 4'b0001);
    seen_r1 = 0;
    seen_d1 = 0;
    d0 = 0;
    drive(4'b0010, 12'h000, 32'h0, 1'b0);
    if (req_ready[1] || done[1]) seen_r1++;
    drive(4'b0010, 12'h000, 32'h0, 1'b1);
    if (req_ready[1]) seen_r1++;
    for (int c = 0; c < 10; c++) begin
      drive(4'b0000, 12'h000, 32'h0, 1'b1);
      if (req_ready[1]) seen_r1++;
      if (done[1]) seen_d1++;
      if (done[0]) d0++;
    end
    check("wd_no_ready1", seen_r1, 0);
    check("wd_no_done1",  seen_d1, 0);
    check("wd_done0_once", d0, 1);
    check("wd_idle", busy, 1'b0);

    // Requester 0 asks while requester 2 holds a 2-tick grant.
    do_reset();
    drive(4'b0100, 12'h080, 32'h0002_0000, 1'b1);
    check("pre_ready2", req_ready, 4'b0100);
    drive(4'b0001, 12'h001, 32'h0, 1'b1);
    check("pre_led_active", {r, g, b}, 3'b010);
    drive(4'b0001, 12'h001, 32'h0, 1'b1);
`ifdef LED_ARBITER_PREEMPT_EN
    check("pre_done2",  done,      4'b0100);
    check("pre_ready0", req_ready, 4'b0001);
    check("pre_led_off", {r, g, b}, 3'b000);
`else
    check("pre_wait_done",  done,      4'b0000);
    check("pre_wait_ready", req_ready, 4'b0000);
    check("pre_wait_led",   {r, g, b}, 3'b010);
    drive(4'b0001, 12'h001, 32'h0, 1'b1);
    check("pre_gap_done",  done,      4'b0100);
    check("pre_gap_ready", req_ready, 4'b0000);
    check("pre_gap_busy",  busy,      1'b1);
    drive(4'b0001, 12'h001, 32'h0, 1'b0);
    check("pre_ready0_rr", req_ready, 4'b0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
